// File: rtl/axi_mem_responder.sv
// ============================================================================
// Module      : axi_mem_responder
// Description : AXI4 subordinate serving one burst at a time from a
//               byte-enabled word memory, with fair AW/AR arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_mem_responder #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 40,
    parameter int ID_WIDTH   = 12,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     axi_awid,
    input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [7:0]              axi_awlen,
    input  logic [2:0]              axi_awsize,
    input  logic [1:0]              axi_awburst,
    input  logic                    axi_awvalid,
    output logic                    axi_awready,
    input  logic [DATA_WIDTH-1:0]   axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                    axi_wlast,
    input  logic                    axi_wvalid,
    output logic                    axi_wready,
    output logic [ID_WIDTH-1:0]     axi_bid,
    output logic [1:0]              axi_bresp,
    output logic                    axi_bvalid,
    input  logic                    axi_bready,
    input  logic [ID_WIDTH-1:0]     axi_arid,
    input  logic [ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [7:0]              axi_arlen,
    input  logic [2:0]              axi_arsize,
    input  logic [1:0]              axi_arburst,
    input  logic                    axi_arvalid,
    output logic                    axi_arready,
    output logic [ID_WIDTH-1:0]     axi_rid,
    output logic [DATA_WIDTH-1:0]   axi_rdata,
    output logic [1:0]              axi_rresp,
    output logic                    axi_rlast,
    output logic                    axi_rvalid,
    input  logic                    axi_rready,
    output logic [15:0]             stat_wr_bursts,
    output logic [15:0]             stat_rd_bursts,
    output logic [15:0]             stat_errors
);

    localparam int c_STRB_W = DATA_WIDTH / 8;
    localparam int c_OFF_W  = $clog2(c_STRB_W);
    localparam int c_IDX_W  = $clog2(MEM_DEPTH);
    localparam int c_TOP_LO = c_OFF_W + c_IDX_W;
    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_BURST_RSVD  = 2'b11;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR_DATA = 2'd1,
        S_WR_RESP = 2'd2,
        S_RD_DATA = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_ptr_wr;
    logic [ID_WIDTH-1:0]   r_id;
    logic [7:0]            r_len;
    logic [7:0]            r_beat;
    logic [c_IDX_W-1:0]    r_idx;
    logic [1:0]            r_burst;
    logic                  r_err;
    logic                  r_oor;
    logic [15:0]           r_wr_cnt;
    logic [15:0]           r_rd_cnt;
    logic [15:0]           r_err_cnt;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic w_aw_grant;
    logic w_ar_grant;
    logic w_last_beat;
    logic w_aw_oor;
    logic w_ar_oor;
    logic w_wr_en;
    logic w_unused;

    assign w_aw_grant  = axi_awvalid & (~axi_arvalid | r_ptr_wr);
    assign w_ar_grant  = axi_arvalid & (~axi_awvalid | ~r_ptr_wr);
    assign w_last_beat = (r_beat == r_len);
    assign w_aw_oor    = |axi_awaddr[ADDR_WIDTH-1:c_TOP_LO];
    assign w_ar_oor    = |axi_araddr[ADDR_WIDTH-1:c_TOP_LO];
    assign w_wr_en     = axi_wready & axi_wvalid & ~r_oor;
    assign w_unused    = ^{axi_awsize, axi_arsize,
                           axi_awaddr[c_OFF_W-1:0], axi_araddr[c_OFF_W-1:0]};

    // Everything visible is forced low while rst is high so an aborted
    // burst cannot leak a handshake during the reset cycle itself.
    always_comb begin
        w_state_nxt = r_state;
        axi_awready = 1'b0;
        axi_arready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        axi_rvalid  = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    axi_awready = w_aw_grant;
                    axi_arready = w_ar_grant;
                    if (w_aw_grant)      w_state_nxt = S_WR_DATA;
                    else if (w_ar_grant) w_state_nxt = S_RD_DATA;
                end
                S_WR_DATA: begin
                    axi_wready = 1'b1;
                    if (axi_wvalid && w_last_beat) w_state_nxt = S_WR_RESP;
                end
                S_WR_RESP: begin
                    axi_bvalid = 1'b1;
                    if (axi_bready) w_state_nxt = S_IDLE;
                end
                S_RD_DATA: begin
                    axi_rvalid = 1'b1;
                    if (axi_rready && w_last_beat) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign axi_bid   = axi_bvalid ? r_id : '0;
    assign axi_bresp = (axi_bvalid && r_err) ? c_RESP_SLVERR : 2'b00;
    assign axi_rid   = axi_rvalid ? r_id : '0;
    assign axi_rresp = (axi_rvalid && r_err) ? c_RESP_SLVERR : 2'b00;
    assign axi_rlast = axi_rvalid & w_last_beat;
    assign axi_rdata = (axi_rvalid && !r_oor) ? r_mem[r_idx] : '0;

    assign stat_wr_bursts = r_wr_cnt;
    assign stat_rd_bursts = r_rd_cnt;
    assign stat_errors    = r_err_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_wr  <= 1'b1;
            r_id      <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_idx     <= '0;
            r_burst   <= '0;
            r_err     <= 1'b0;
            r_oor     <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (axi_awready) begin
                        r_id    <= axi_awid;
                        r_len   <= axi_awlen;
                        r_idx   <= axi_awaddr[c_OFF_W +: c_IDX_W];
                        r_burst <= axi_awburst;
                        r_beat  <= '0;
                        r_oor   <= w_aw_oor;
                        r_err   <= w_aw_oor | (axi_awburst == c_BURST_RSVD);
                        if (axi_arvalid) r_ptr_wr <= 1'b0;
                    end else if (axi_arready) begin
                        r_id    <= axi_arid;
                        r_len   <= axi_arlen;
                        r_idx   <= axi_araddr[c_OFF_W +: c_IDX_W];
                        r_burst <= axi_arburst;
                        r_beat  <= '0;
                        r_oor   <= w_ar_oor;
                        r_err   <= w_ar_oor | (axi_arburst == c_BURST_RSVD);
                        if (axi_awvalid) r_ptr_wr <= 1'b1;
                    end
                end
                S_WR_DATA: begin
                    if (axi_wvalid) begin
                        r_beat <= r_beat + 8'd1;
                        if (r_burst != c_BURST_FIXED) r_idx <= r_idx + c_IDX_W'(1);
                        if (axi_wlast != w_last_beat) r_err <= 1'b1;
                    end
                end
                S_WR_RESP: begin
                    if (axi_bready) begin
                        r_wr_cnt <= sat_inc(r_wr_cnt);
                        if (r_err) r_err_cnt <= sat_inc(r_err_cnt);
                    end
                end
                S_RD_DATA: begin
                    if (axi_rready) begin
                        if (w_last_beat) begin
                            r_rd_cnt <= sat_inc(r_rd_cnt);
                            if (r_err) r_err_cnt <= sat_inc(r_err_cnt);
                        end else begin
                            r_beat <= r_beat + 8'd1;
                            if (r_burst != c_BURST_FIXED) r_idx <= r_idx + c_IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < c_STRB_W; b++) begin
                if (axi_wstrb[b]) r_mem[r_idx][8*b +: 8] <= axi_wdata[8*b +: 8];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
// ============================================================================
// Module      : tb_axi_mem_responder
// Description : Directed self-checking bench for axi_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] axi_awid, axi_arid, axi_bid, axi_rid;
    logic [39:0] axi_awaddr, axi_araddr;
    logic [7:0]  axi_awlen, axi_arlen, axi_wstrb;
    logic [2:0]  axi_awsize, axi_arsize;
    logic [1:0]  axi_awburst, axi_arburst, axi_bresp, axi_rresp;
    logic        axi_awvalid, axi_awready, axi_arvalid, axi_arready;
    logic [63:0] axi_wdata, axi_rdata;
    logic        axi_wlast, axi_wvalid, axi_wready;
    logic        axi_bvalid, axi_bready;
    logic        axi_rlast, axi_rvalid, axi_rready;
    logic [15:0] stat_wr_bursts, stat_rd_bursts, stat_errors;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_mem_responder dut (
        .clk(clk), .rst(rst),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .stat_wr_bursts(stat_wr_bursts), .stat_rd_bursts(stat_rd_bursts),
        .stat_errors(stat_errors)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_aw(input logic [11:0] id, input logic [39:0] addr, input logic [7:0] len);
        axi_awid = id; axi_awaddr = addr; axi_awlen = len;
        axi_awsize = 3'd3; axi_awburst = 2'b01; axi_awvalid = 1'b1;
    endtask

    task automatic set_ar(input logic [11:0] id, input logic [39:0] addr, input logic [7:0] len);
        axi_arid = id; axi_araddr = addr; axi_arlen = len;
        axi_arsize = 3'd3; axi_arburst = 2'b01; axi_arvalid = 1'b1;
    endtask

    task automatic do_aw(input logic [11:0] id, input logic [39:0] addr, input logic [7:0] len);
        int n = 0;
        @(negedge clk); set_aw(id, addr, len); #1;
        while (!axi_awready && n < 50) begin @(negedge clk); #1; n++; end
        chk("aw_handshake", 64'(n < 50), 64'd1);
        @(posedge clk); #1; axi_awvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [11:0] id, input logic [39:0] addr, input logic [7:0] len);
        int n = 0;
        @(negedge clk); set_ar(id, addr, len); #1;
        while (!axi_arready && n < 50) begin @(negedge clk); #1; n++; end
        chk("ar_handshake", 64'(n < 50), 64'd1);
        @(posedge clk); #1; axi_arvalid = 1'b0;
    endtask

    task automatic do_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n = 0;
        @(negedge clk); axi_wdata = data; axi_wstrb = strb; axi_wlast = last; axi_wvalid = 1'b1; #1;
        while (!axi_wready && n < 50) begin @(negedge clk); #1; n++; end
        chk("w_handshake", 64'(n < 50), 64'd1);
        @(posedge clk); #1; axi_wvalid = 1'b0; axi_wlast = 1'b0;
    endtask

    task automatic do_b(input logic [11:0] id, input logic [1:0] resp);
        int n = 0;
        @(negedge clk); axi_bready = 1'b1; #1;
        while (!axi_bvalid && n < 50) begin @(negedge clk); #1; n++; end
        chk("b_handshake", 64'(n < 50), 64'd1);
        chk("bid", 64'(axi_bid), 64'(id));
        chk("bresp", 64'(axi_bresp), 64'(resp));
        @(posedge clk); #1; axi_bready = 1'b0;
    endtask

    task automatic do_r(input logic [63:0] data, input logic last, input logic [11:0] id,
                        input logic [1:0] resp);
        int n = 0;
        @(negedge clk); axi_rready = 1'b1; #1;
        while (!axi_rvalid && n < 50) begin @(negedge clk); #1; n++; end
        chk("r_handshake", 64'(n < 50), 64'd1);
        chk("rdata", axi_rdata, data);
        chk("rlast", 64'(axi_rlast), 64'(last));
        chk("rid", 64'(axi_rid), 64'(id));
        chk("rresp", 64'(axi_rresp), 64'(resp));
        @(posedge clk); #1; axi_rready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        axi_awvalid = 1'b0; axi_arvalid = 1'b0; axi_wvalid = 1'b0;
        axi_bready = 1'b0; axi_rready = 1'b0; axi_wlast = 1'b0;
        axi_wdata = '0; axi_wstrb = '0;
        set_aw(0, 0, 0); set_ar(0, 0, 0);
        axi_awvalid = 1'b0; axi_arvalid = 1'b0;

        // reset: readies stay low even with requests pending
        repeat (2) @(posedge clk);
        @(negedge clk); axi_awvalid = 1'b1; axi_arvalid = 1'b1; #1;
        chk("rst_awready", 64'(axi_awready), 64'd0);
        chk("rst_arready", 64'(axi_arready), 64'd0);
        chk("rst_valids", 64'({axi_wready, axi_bvalid, axi_rvalid, axi_rlast}), 64'd0);
        chk("rst_ids", 64'({axi_bid, axi_rid, axi_bresp, axi_rresp}), 64'd0);
        chk("rst_rdata", axi_rdata, 64'd0);
        chk("rst_stats", 64'({stat_wr_bursts, stat_rd_bursts, stat_errors}), 64'd0);
        @(negedge clk); axi_awvalid = 1'b0; axi_arvalid = 1'b0; rst = 1'b0;

        // INCR write/read of four beats
        do_aw(12'h123, 40'h40, 8'd3);
        for (int i = 0; i < 4; i++) do_w(64'hA0 + 64'(i), 8'hFF, i == 3);
        do_b(12'h123, 2'b00);
        do_ar(12'h456, 40'h40, 8'd3);
        for (int i = 0; i < 4; i++) do_r(64'hA0 + 64'(i), i == 3, 12'h456, 2'b00);
        @(negedge clk);
        chk("stat_wr_1", 64'(stat_wr_bursts), 64'd1);
        chk("stat_rd_1", 64'(stat_rd_bursts), 64'd1);

        // partial strobe merge
        do_aw(12'h001, 40'h100, 8'd0);
        do_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
        do_b(12'h001, 2'b00);
        do_aw(12'h002, 40'h100, 8'd0);
        do_w(64'h1111_2222_3333_4444, 8'h0F, 1'b1);
        do_b(12'h002, 2'b00);
        do_ar(12'h003, 40'h100, 8'd0);
        do_r(64'hFFFF_FFFF_3333_4444, 1'b1, 12'h003, 2'b00);

        // index wrap from word 254 to word 1
        do_aw(12'h004, 40'h7F0, 8'd3);
        for (int i = 0; i < 4; i++) do_w(64'hC0 + 64'(i), 8'hFF, i == 3);
        do_b(12'h004, 2'b00);
        do_ar(12'h005, 40'h7F0, 8'd3);
        for (int i = 0; i < 4; i++) do_r(64'hC0 + 64'(i), i == 3, 12'h005, 2'b00);
        do_ar(12'h006, 40'h0, 8'd1);
        do_r(64'hC2, 1'b0, 12'h006, 2'b00);
        do_r(64'hC3, 1'b1, 12'h006, 2'b00);

        // out-of-range write dropped, read returns zero
        do_aw(12'h007, 40'h10_0000_0000, 8'd1);
        do_w(64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1'b0);
        do_w(64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1'b1);
        do_b(12'h007, 2'b10);
        do_ar(12'h008, 40'h0, 8'd0);
        do_r(64'hC2, 1'b1, 12'h008, 2'b00);
        do_ar(12'h009, 40'h10_0000_0000, 8'd0);
        do_r(64'h0, 1'b1, 12'h009, 2'b10);
        @(negedge clk);
        chk("stat_wr_5", 64'(stat_wr_bursts), 64'd5);
        chk("stat_rd_6", 64'(stat_rd_bursts), 64'd6);
        chk("stat_err_2", 64'(stat_errors), 64'd2);

        // arbitration: write, read, write
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); set_aw(12'h001, 40'h80, 8'd0); set_ar(12'h002, 40'h80, 8'd0); #1;
        chk("arb1_aw", 64'(axi_awready), 64'd1);
        chk("arb1_ar", 64'(axi_arready), 64'd0);
        @(posedge clk); #1; axi_awvalid = 1'b0; axi_arvalid = 1'b0;
        do_w(64'h1234, 8'hFF, 1'b1);
        do_b(12'h001, 2'b00);
        @(negedge clk); set_aw(12'h003, 40'h88, 8'd0); set_ar(12'h002, 40'h80, 8'd0); #1;
        chk("arb2_aw", 64'(axi_awready), 64'd0);
        chk("arb2_ar", 64'(axi_arready), 64'd1);
        @(posedge clk); #1; axi_awvalid = 1'b0; axi_arvalid = 1'b0;
        do_r(64'h1234, 1'b1, 12'h002, 2'b00);
        @(negedge clk); set_aw(12'h003, 40'h88, 8'd0); set_ar(12'h002, 40'h80, 8'd0); #1;
        chk("arb3_aw", 64'(axi_awready), 64'd1);
        chk("arb3_ar", 64'(axi_arready), 64'd0);
        @(posedge clk); #1; axi_awvalid = 1'b0; axi_arvalid = 1'b0;
        do_w(64'h5678, 8'hFF, 1'b1);
        do_b(12'h003, 2'b00);

        // R back-pressure mid burst
        do_ar(12'h00A, 40'h40, 8'd3);
        do_r(64'hA0, 1'b0, 12'h00A, 2'b00);
        repeat (5) begin
            @(negedge clk); #1;
            chk("rstall_valid", 64'(axi_rvalid), 64'd1);
            chk("rstall_data", axi_rdata, 64'hA1);
            chk("rstall_last", 64'(axi_rlast), 64'd0);
        end
        for (int i = 1; i < 4; i++) do_r(64'hA0 + 64'(i), i == 3, 12'h00A, 2'b00);

        // B back-pressure
        do_aw(12'h00B, 40'h90, 8'd0);
        do_w(64'h9999, 8'hFF, 1'b1);
        repeat (3) begin
            @(negedge clk); #1;
            chk("bstall_valid", 64'(axi_bvalid), 64'd1);
            chk("bstall_id", 64'(axi_bid), 64'h00B);
        end
        do_b(12'h00B, 2'b00);

        // reset during the third beat of a four-beat write
        do_aw(12'h00C, 40'h200, 8'd3);
        do_w(64'hD0, 8'hFF, 1'b0);
        do_w(64'hD1, 8'hFF, 1'b0);
        @(negedge clk); axi_wdata = 64'hD2; axi_wstrb = 8'hFF; axi_wvalid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_outs", 64'({axi_wready, axi_bvalid, axi_rvalid, axi_awready, axi_arready}), 64'd0);
        @(negedge clk); rst = 1'b0; axi_wvalid = 1'b0; #1;
        chk("midrst_wready", 64'(axi_wready), 64'd0);
        repeat (3) begin
            @(negedge clk); #1;
            chk("midrst_no_b", 64'(axi_bvalid), 64'd0);
        end
        do_ar(12'h00D, 40'h200, 8'd1);
        do_r(64'hD0, 1'b0, 12'h00D, 2'b00);
        do_r(64'hD1, 1'b1, 12'h00D, 2'b00);
        @(negedge clk);
        chk("midrst_stat_wr", 64'(stat_wr_bursts), 64'd0);
        chk("midrst_stat_rd", 64'(stat_rd_bursts), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
